// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   DATA_BITS       - payload bits per frame
//   uart_rx_state_e - receiver FSM state encoding
//   parity_bit()    - parity bit to send or expect for a data byte
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_rx_state_e;

  // even=1: the bit makes the total count of ones even (bit = ^data); odd otherwise.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic even);
    return even ? (^data) : (~^data);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
//   clk  - sampling clock
//   rst  - synchronous active-high reset; both flops reset to 1 (line idle)
//   rx   - asynchronous serial input
//   rx_s - synchronized line, two clocks behind rx
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, LSB first, optional even/odd parity, one stop bit.
//   clk, rst            - clock and synchronous active-high reset
//   rx                  - asynchronous serial line, idle high
//   parity_en           - frame carries a parity bit (latched at start-bit centre)
//   even_parity         - 1 = even parity, 0 = odd (latched with parity_en)
//   rx_ready            - consumer takes data_out when data_valid && rx_ready
//   data_out            - last committed byte, held until accepted
//   data_valid          - data_out holds an unconsumed byte
//   parity_err          - parity mismatch for the byte in data_out
//   frame_err           - one-cycle pulse, stop bit sampled low
//   overrun_err         - one-cycle pulse, byte dropped because data_out was still full
//   rx_busy             - receiver FSM is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 even_parity,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s)
  );

  uart_rx_state_e       state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 pe_q, pe_n;
  logic                 even_q, even_n;
  logic                 pflag, pflag_n;
  logic [DATA_BITS-1:0] data_out_n;
  logic                 data_valid_n, parity_err_n, frame_err_n, overrun_err_n, rx_busy_n;
  logic                 sample, commit;

  // Registers: FSM state, frame datapath and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      pe_q        <= 1'b0;
      even_q      <= 1'b0;
      pflag       <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shift       <= shift_n;
      pe_q        <= pe_n;
      even_q      <= even_n;
      pflag       <= pflag_n;
      data_out    <= data_out_n;
      data_valid  <= data_valid_n;
      parity_err  <= parity_err_n;
      frame_err   <= frame_err_n;
      overrun_err <= overrun_err_n;
      rx_busy     <= rx_busy_n;
    end
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    idx_n         = idx;
    shift_n       = shift;
    pe_n          = pe_q;
    even_n        = even_q;
    pflag_n       = pflag;
    commit        = 1'b0;
    frame_err_n   = 1'b0;
    overrun_err_n = 1'b0;
    data_out_n    = data_out;
    data_valid_n  = data_valid;
    parity_err_n  = parity_err;

    // Mid-bit sample point for DATA/PARITY/STOP; the counter wraps there.
    sample = (cnt == BIT_LAST);

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = DATA;
            idx_n   = '0;
            pe_n    = parity_en;
            even_n  = even_parity;
            pflag_n = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (sample) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[DATA_BITS-1:1]};
          if (idx == IDX_LAST) begin
            state_n = pe_q ? PARITY : STOP;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        if (sample) begin
          cnt_n   = '0;
          pflag_n = (rx_s != parity_bit(shift, even_q));
          state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (sample) begin
          cnt_n = '0;
          if (rx_s) begin
            commit  = 1'b1;
            state_n = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    if (data_valid && rx_ready) begin
      data_valid_n = 1'b0;
    end

    // A commit overruns only if the held byte is not being taken this same cycle.
    if (commit) begin
      if (data_valid && !rx_ready) begin
        overrun_err_n = 1'b1;
      end else begin
        data_out_n   = shift;
        parity_err_n = pflag;
        data_valid_n = 1'b1;
      end
    end

    rx_busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (CLKS_PER_BIT = 16).
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst, rx, parity_en, even_parity, rx_ready;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, overrun_err, rx_busy;

  int vectors     = 0;
  int miscompares = 0;
  int ferr_cnt    = 0;
  int ovr_cnt     = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .parity_en   (parity_en),
    .even_parity (even_parity),
    .rx_ready    (rx_ready),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  // Count high cycles of the pulse outputs, sampled mid-period.
  always @(negedge clk) begin
    if (frame_err)   ferr_cnt++;
    if (overrun_err) ovr_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       even;
    logic       flip;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_perr;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference parity: count ones, pick the bit that gives the requested total parity.
  function automatic logic ref_par(input logic [7:0] d, input logic even);
    int  ones;
    logic odd;
    ones = $countones(d);
    odd  = (ones % 2) == 1;
    return even ? odd : !odd;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic even,
                            input logic flip, input logic stop);
    parity_en   = pe;
    even_parity = even;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pe) drive_bit(ref_par(d, even) ^ flip);
    drive_bit(stop);
  endtask

  // After a low stop bit: keep the line low, confirm still busy, then release.
  task automatic finish_bad_stop(input string tag);
    rx = 1'b0;
    tick(40 - CPB);
    check({tag, "_busy_low"}, 32'(rx_busy), 32'd1);
    rx = 1'b1;
    tick(4);
    check({tag, "_busy_idle"}, 32'(rx_busy), 32'd0);
  endtask

  task automatic accept(input string tag);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check({tag, "_accept"}, 32'(data_valid), 32'd0);
  endtask

  logic [7:0] m_data;
  logic       m_valid, m_perr;

  initial begin
    //          data   pe    even  flip  stop  exp_d  vld   perr  ferr
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 0};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 0};
    vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 0};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 0};
    vecs[6] = '{8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 0};

    rst = 1'b1; rx = 1'b1; parity_en = 1'b0; even_parity = 1'b0; rx_ready = 1'b0;
    tick(4);
    check("rst_data",  32'(data_out),    32'h00);
    check("rst_valid", 32'(data_valid),  32'd0);
    check("rst_perr",  32'(parity_err),  32'd0);
    check("rst_ferr",  32'(frame_err),   32'd0);
    check("rst_ovr",   32'(overrun_err), 32'd0);
    check("rst_busy",  32'(rx_busy),     32'd0);
    rst = 1'b0;
    tick(3);

    // Table of single frames, each followed by acceptance of the byte.
    for (int v = 0; v < 7; v++) begin
      ferr_cnt = 0; ovr_cnt = 0;
      send_frame(vecs[v].data, vecs[v].pe, vecs[v].even, vecs[v].flip, vecs[v].stop);
      if (!vecs[v].stop) finish_bad_stop($sformatf("vec%0d", v));
      check($sformatf("vec%0d_data", v),  32'(data_out),   32'(vecs[v].exp_data));
      check($sformatf("vec%0d_valid", v), 32'(data_valid), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid)
        check($sformatf("vec%0d_perr", v), 32'(parity_err), 32'(vecs[v].exp_perr));
      check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt), 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_ovr", v),  32'(ovr_cnt),  32'd0);
      if (data_valid) accept($sformatf("vec%0d", v));
      tick(2);
    end

    // Back-to-back frames with no consumer: second byte dropped, one overrun pulse.
    ferr_cnt = 0; ovr_cnt = 0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_data",  32'(data_out),   32'h11);
    check("ovr_valid", 32'(data_valid), 32'd1);
    check("ovr_pulse", 32'(ovr_cnt),    32'd1);
    check("ovr_ferr",  32'(ferr_cnt),   32'd0);
    accept("ovr");
    tick(2);

    // Consumer accepts the old byte on the commit cycle of the next one.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    ovr_cnt = 0;
    fork
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    check("same_data",  32'(data_out),   32'hC3);
    check("same_valid", 32'(data_valid), 32'd1);
    check("same_ovr",   32'(ovr_cnt),    32'd0);
    accept("same");
    tick(2);

    // Short low glitch on the idle line is rejected as a false start.
    ferr_cnt = 0;
    rx = 1'b0;
    tick(4);
    check("glitch_busy_hi", 32'(rx_busy), 32'd1);
    rx = 1'b1;
    tick(12);
    check("glitch_busy_lo", 32'(rx_busy),    32'd0);
    check("glitch_valid",   32'(data_valid), 32'd0);
    check("glitch_data",    32'(data_out),   32'hC3);
    check("glitch_ferr",    32'(ferr_cnt),   32'd0);

    // Reset during the 4th data bit of 0xFF, then a clean frame.
    parity_en = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx = 1'b1;
    tick(CPB / 2);
    rst = 1'b1;
    tick(1);
    check("mid_rst_data",  32'(data_out),    32'h00);
    check("mid_rst_valid", 32'(data_valid),  32'd0);
    check("mid_rst_perr",  32'(parity_err),  32'd0);
    check("mid_rst_ferr",  32'(frame_err),   32'd0);
    check("mid_rst_ovr",   32'(overrun_err), 32'd0);
    check("mid_rst_busy",  32'(rx_busy),     32'd0);
    rst = 1'b0;
    tick(3);
    ferr_cnt = 0; ovr_cnt = 0;
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("post_rst_data",  32'(data_out),   32'hF0);
    check("post_rst_valid", 32'(data_valid), 32'd1);
    check("post_rst_perr",  32'(parity_err), 32'd0);
    check("post_rst_err",   32'(ferr_cnt + ovr_cnt), 32'd0);
    accept("post_rst");
    tick(2);

    // Random frames against a byte-level model of the receive buffer.
    m_data = 8'hF0; m_valid = 1'b0; m_perr = 1'b0;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic       pe, ev, fl, st;
      int         e_ferr, e_ovr;
      d  = 8'($urandom);
      pe = 1'($urandom_range(0, 1));
      ev = 1'($urandom_range(0, 1));
      fl = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 5) != 0);
      ferr_cnt = 0; ovr_cnt = 0;
      send_frame(d, pe, ev, fl, st);
      e_ferr = 0; e_ovr = 0;
      if (!st) begin
        e_ferr = 1;
        finish_bad_stop($sformatf("rnd%0d", n));
      end else if (m_valid) begin
        e_ovr = 1;
      end else begin
        m_data  = d;
        m_valid = 1'b1;
        m_perr  = pe && fl;
      end
      check($sformatf("rnd%0d_data", n),  32'(data_out),   32'(m_data));
      check($sformatf("rnd%0d_valid", n), 32'(data_valid), 32'(m_valid));
      if (m_valid) check($sformatf("rnd%0d_perr", n), 32'(parity_err), 32'(m_perr));
      check($sformatf("rnd%0d_ferr", n), 32'(ferr_cnt), 32'(e_ferr));
      check($sformatf("rnd%0d_ovr", n),  32'(ovr_cnt),  32'(e_ovr));
      if (m_valid && ($urandom_range(0, 2) != 0)) begin
        accept($sformatf("rnd%0d", n));
        m_valid = 1'b0;
      end
      tick(int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
